// File: rtl/mem_access_stage.sv
// Memory-access stage: req/ack data-memory port, lane steering and load extension.
// Optional macro MEM_SUBWORD_EN enables byte/half accesses; without it every access is a word access.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  write_reg_addr,
    input  logic        reg_write,
    input  logic        mem_reg,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] mem_read_data,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_addr_out,
    output logic        reg_write_out,
    output logic        mem_reg_out,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10} state_t;

    state_t      state, state_next;
    logic [1:0]  acc_size;
    logic        acc_uns;
    logic        access, misaligned, accept;
    logic [1:0]  lo_q, size_q;
    logic        uns_q, reg_write_q, mem_reg_q;
    logic [31:0] alu_q, rdata_q;
    logic [4:0]  wreg_q;
    logic        stall_c, reg_write_c, mem_reg_c, misalign_c;

`ifdef MEM_SUBWORD_EN
    assign acc_size = mem_size;
    assign acc_uns  = mem_unsigned;
`else
    logic unused_cfg;
    assign acc_size   = 2'b10;
    assign acc_uns    = 1'b0;
    assign unused_cfg = ^{mem_size, mem_unsigned};
`endif

    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lo[0];
            default: r = (lo != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] r;
        case (size)
            2'b00:   r = 4'b0001 << lo;
            2'b01:   r = lo[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_f(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign access     = valid & (mem_read | mem_write);
    assign misaligned = misaligned_f(acc_size, alu_result[1:0]);
    assign accept     = (state == IDLE) & access & ~misaligned;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and output selection; DONE replays the captured copies.
    always_comb begin
        state_next         = state;
        stall_c            = 1'b0;
        reg_write_c        = 1'b0;
        mem_reg_c          = 1'b0;
        misalign_c         = 1'b0;
        mem_read_data      = 32'h0000_0000;
        alu_result_out     = alu_result;
        write_reg_addr_out = write_reg_addr;
        case (state)
            IDLE: begin
                if (!access) begin
                    reg_write_c = valid & reg_write;
                    mem_reg_c   = valid & mem_reg;
                end else if (misaligned) begin
                    misalign_c = 1'b1;
                end else begin
                    state_next = WAIT;
                    stall_c    = 1'b1;
                end
            end
            WAIT: begin
                stall_c    = 1'b1;
                state_next = dmem_ack ? DONE : WAIT;
            end
            DONE: begin
                state_next         = IDLE;
                alu_result_out     = alu_q;
                write_reg_addr_out = wreg_q;
                reg_write_c        = reg_write_q & ~dmem_we;
                mem_reg_c          = mem_reg_q;
                mem_read_data      = rdata_q;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall         = rst & stall_c;
    assign reg_write_out = rst & reg_write_c;
    assign mem_reg_out   = rst & mem_reg_c;
    assign misalign_exc  = rst & misalign_c;

    // Request/datapath registers: loaded on accept, load data captured on ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'h0000_0000;
            dmem_wdata  <= 32'h0000_0000;
            dmem_be     <= 4'b0000;
            rdata_q     <= 32'h0000_0000;
            lo_q        <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            alu_q       <= 32'h0000_0000;
            wreg_q      <= 5'd0;
            reg_write_q <= 1'b0;
            mem_reg_q   <= 1'b0;
        end else if (accept) begin
            dmem_req    <= 1'b1;
            dmem_we     <= mem_write;
            dmem_addr   <= {alu_result[31:2], 2'b00};
            dmem_wdata  <= wdata_f(acc_size, write_data);
            dmem_be     <= be_f(acc_size, alu_result[1:0]);
            lo_q        <= alu_result[1:0];
            size_q      <= acc_size;
            uns_q       <= acc_uns;
            alu_q       <= alu_result;
            wreg_q      <= write_reg_addr;
            reg_write_q <= reg_write;
            mem_reg_q   <= mem_reg;
        end else if ((state == WAIT) && dmem_ack) begin
            dmem_req <= 1'b0;
            rdata_q  <= extract_f(size_q, uns_q, lo_q, dmem_rdata);
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; expectations follow MEM_SUBWORD_EN.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst, valid, reg_write, mem_reg, mem_read, mem_write, mem_unsigned, dmem_ack;
    logic [31:0] alu_result, write_data, dmem_rdata;
    logic [4:0]  write_reg_addr;
    logic [1:0]  mem_size;
    logic        dmem_req, dmem_we, stall, reg_write_out, mem_reg_out, misalign_exc;
    logic [31:0] dmem_addr, dmem_wdata, mem_read_data, alu_result_out;
    logic [3:0]  dmem_be;
    logic [4:0]  write_reg_addr_out;
    int          checks = 0;
    int          errors = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .valid(valid), .alu_result(alu_result), .write_data(write_data),
        .write_reg_addr(write_reg_addr), .reg_write(reg_write), .mem_reg(mem_reg),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .mem_read_data(mem_read_data), .alu_result_out(alu_result_out),
        .write_reg_addr_out(write_reg_addr_out), .reg_write_out(reg_write_out),
        .mem_reg_out(mem_reg_out), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic no_instr();
        valid = 1'b0; reg_write = 1'b0; mem_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'b10; mem_unsigned = 1'b0; alu_result = 32'h0; write_data = 32'h0;
        write_reg_addr = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic mem_op(input logic rd, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        valid = 1'b1; mem_read = rd; mem_write = ~rd; reg_write = rd; mem_reg = rd;
        mem_size = sz; mem_unsigned = uns; alu_result = addr; write_data = wd;
        write_reg_addr = 5'd9;
    endtask

    initial begin
        rst = 1'b0;
        no_instr();
        tick(); tick();
        settle();
        chk("rst_stall", stall, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_rw", reg_write_out, 1'b0);

        // Reset held for two cycles in the middle of a WAIT.
        rst = 1'b1;
        tick();
        mem_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
        settle();
        chk("acc_stall", stall, 1'b1);
        tick();
        settle();
        chk("wait_req", dmem_req, 1'b1);
        rst = 1'b0;
        settle();
        chk("rstlow_stall", stall, 1'b0);
        chk("rstlow_rw", reg_write_out, 1'b0);
        tick();
        settle();
        chk("rst1_req", dmem_req, 1'b0);
        chk("rst1_addr", dmem_addr, 32'h0);
        tick();
        settle();
        chk("rst2_stall", stall, 1'b0);
        chk("rst2_be", {dmem_we, dmem_be}, 5'b0);
        chk("rst2_wdata", dmem_wdata, 32'h0);
        chk("rst2_mrd", mem_read_data, 32'h0);
        chk("rst2_misalign", misalign_exc, 1'b0);
        no_instr();
        rst = 1'b1;
        tick();

        // Word load at 0x100, ack on the third WAIT cycle.
        mem_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
        settle();
        chk("wl_c0_stall", stall, 1'b1);
        chk("wl_c0_bubble", {reg_write_out, mem_reg_out}, 2'b00);
        tick();
        settle();
        chk("wl_w1_stall", stall, 1'b1);
        chk("wl_w1_req", dmem_req, 1'b1);
        chk("wl_w1_addr", dmem_addr, 32'h100);
        chk("wl_w1_we_be", {dmem_we, dmem_be}, 5'b0_1111);
        chk("wl_w1_bubble", reg_write_out, 1'b0);
        tick();
        settle();
        chk("wl_w2_stall", stall, 1'b1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        settle();
        chk("wl_w3_stall", stall, 1'b1);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        settle();
        chk("wl_done_stall", stall, 1'b0);
        chk("wl_done_data", mem_read_data, 32'hDEADBEEF);
        chk("wl_done_rw", reg_write_out, 1'b1);
        chk("wl_done_mr", mem_reg_out, 1'b1);
        chk("wl_done_wra", write_reg_addr_out, 5'd9);
        chk("wl_done_alu", alu_result_out, 32'h100);
        chk("wl_done_req", dmem_req, 1'b0);
        tick();
        no_instr();
        settle();
        chk("wl_after_rw", reg_write_out, 1'b0);
        chk("wl_after_mrd", mem_read_data, 32'h0);

`ifdef MEM_SUBWORD_EN
        // Byte loads at 0x103, signed then unsigned back-to-back.
        mem_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h0);
        settle();
        chk("lb_stall", stall, 1'b1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h80112233;
        settle();
        chk("lb_addr", dmem_addr, 32'h100);
        tick();
        dmem_ack = 1'b0;
        settle();
        chk("lb_data", mem_read_data, 32'hFFFFFF80);
        chk("lb_rw", reg_write_out, 1'b1);
        tick();
        mem_op(1'b1, 2'b00, 1'b1, 32'h103, 32'h0);
        settle();
        chk("lbu_accept", stall, 1'b1);
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        settle();
        chk("lbu_data", mem_read_data, 32'h00000080);
        tick();

        // Half store at 0x202.
        mem_op(1'b0, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
        reg_write = 1'b1;
        settle();
        chk("sh_stall", stall, 1'b1);
        tick();
        dmem_ack = 1'b1;
        settle();
        chk("sh_we", dmem_we, 1'b1);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_addr", dmem_addr, 32'h200);
        tick();
        dmem_ack = 1'b0;
        settle();
        chk("sh_done_rw", reg_write_out, 1'b0);
        chk("sh_done_stall", stall, 1'b0);
        tick();
`else
        // Without sub-word support these are word accesses and thus misaligned.
        mem_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h0);
        settle();
        chk("lb_misalign", misalign_exc, 1'b1);
        chk("lb_stall", stall, 1'b0);
        mem_op(1'b0, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
        settle();
        chk("sh_misalign", misalign_exc, 1'b1);
        chk("sh_stall", stall, 1'b0);
        tick();
        // Half load of an aligned word address returns the raw word.
        mem_op(1'b1, 2'b01, 1'b0, 32'h104, 32'h0);
        settle();
        chk("lh_stall", stall, 1'b1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h80112233;
        settle();
        chk("lh_be", dmem_be, 4'b1111);
        tick();
        dmem_ack = 1'b0;
        settle();
        chk("lh_raw", mem_read_data, 32'h80112233);
        tick();
`endif

        // Word store at 0x300.
        mem_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h12345678);
        settle();
        chk("sw_stall", stall, 1'b1);
        tick();
        dmem_ack = 1'b1;
        settle();
        chk("sw_wdata", dmem_wdata, 32'h12345678);
        chk("sw_we_be", {dmem_we, dmem_be}, 5'b1_1111);
        tick();
        dmem_ack = 1'b0;
        settle();
        chk("sw_done_rw", reg_write_out, 1'b0);
        tick();

        // Misaligned word load at 0x101.
        mem_op(1'b1, 2'b10, 1'b0, 32'h101, 32'h0);
        settle();
        chk("mis_exc", misalign_exc, 1'b1);
        chk("mis_stall", stall, 1'b0);
        chk("mis_rw", reg_write_out, 1'b0);
        chk("mis_req", dmem_req, 1'b0);
        tick();
        no_instr();
        settle();
        chk("mis_exc_off", misalign_exc, 1'b0);
        chk("mis_req_after", dmem_req, 1'b0);

        // Non-memory add with a spurious ack in IDLE.
        valid = 1'b1; reg_write = 1'b1; alu_result = 32'h42; write_reg_addr = 5'd7;
        dmem_ack = 1'b1;
        settle();
        chk("add_alu", alu_result_out, 32'h42);
        chk("add_rw", reg_write_out, 1'b1);
        chk("add_wra", write_reg_addr_out, 5'd7);
        chk("add_stall", stall, 1'b0);
        chk("add_mrd", mem_read_data, 32'h0);
        tick();
        alu_result = 32'h55;
        settle();
        chk("ack_idle_alu", alu_result_out, 32'h55);
        chk("ack_idle_req", dmem_req, 1'b0);
        chk("ack_idle_stall", stall, 1'b0);
        no_instr();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage between the EX/MEM and MEM/WB pipeline registers. It takes the address, store data and control from EX/MEM and performs loads and stores on a req/ack data-memory port. Load data is byte-lane selected and extended before it goes to MEM/WB. While an access is outstanding it stalls the upstream pipeline and sends bubbles downstream.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-low (sampled on the rising edge of clk, asserted when 0)
- valid  in  1  EX/MEM slot holds a live instruction
- alu_result  in  32  effective address, or ALU value for non-memory instructions
- write_data  in  32  store data (rt)
- write_reg_addr  in  5  destination register
- reg_write, mem_reg  in  1 each  writeback controls, passed through
- mem_read, mem_write  in  1 each  load / store
- mem_size  in  2  00 byte, 01 half, 10 word (11 is treated as word)
- mem_unsigned  in  1  zero-extend loads (lbu/lhu)
- dmem_req  out  1  request strobe
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables, little-endian
- dmem_ack  in  1  request complete; rdata valid in the same cycle
- dmem_rdata  in  32  read word
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- mem_read_data, alu_result_out  out  32 each  to MEM/WB
- write_reg_addr_out  out  5  to MEM/WB
- reg_write_out, mem_reg_out  out  1 each  to MEM/WB
- misalign_exc  out  1  misaligned access detected (one cycle per instruction)

## Operation
- FSM states: IDLE, WAIT, DONE.
- An access is `valid & (mem_read|mem_write)`.
- Alignment:
  - A word access is misaligned if addr[1:0]≠0.
  - A half access is misaligned if addr[0]≠0.
- IDLE:
  - Non-access or invalid instruction: combinational pass-through, stall=0, mem_read_data=0.
  - Aligned access: register address, controls, be and wdata; go to WAIT; stall=1; output a bubble.
  - Misaligned access: no request; misalign_exc=1, reg_write_out=0, stall=0; stay in IDLE.
- WAIT:
  - dmem_req=1, stall=1, bubble out.
  - When dmem_ack=1: capture the extended load data into rdata_q, drop dmem_req, go to DONE.
- DONE: stall=0; outputs come from the captured registers (load value in mem_read_data; stores give reg_write_out=0); go to IDLE.
- Bubble means reg_write_out=0 and mem_reg_out=0. The other outputs are don't-care.
- Store lanes:
  - Byte: wdata={4{b}}, be=0001<<addr[1:0].
  - Half: wdata={2{h}}, be=addr[1]?1100:0011.
  - Word: be=1111.
- Load extract:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - Sign-extend unless mem_unsigned.

## Timing
- Reset (rst=0 at an edge):
  - State returns to IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be and rdata_q all become 0.
  - While rst=0: stall=0, reg_write_out=0, mem_reg_out=0, misalign_exc=0.
- Reset during WAIT abandons the access; dmem_req is 0 from the next cycle.
- dmem_ack is ignored in IDLE and DONE.
- Access latency: accept in cycle 0 (IDLE), WAIT from cycle 1. Ack in cycle k means DONE in cycle k+1, and MEM/WB captures at the end of k+1.
- With ack in the first WAIT cycle, stall is high for 2 cycles.
- dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable while dmem_req=1.
- Inputs are frozen by stall during WAIT. The registered copies are authoritative.
- A back-to-back access presented in the cycle after DONE is accepted normally (IDLE).

## Configuration
- MEM_SUBWORD_EN defined: byte and half accesses behave as above.
- MEM_SUBWORD_EN not defined:
  - mem_size and mem_unsigned are ignored; every access is a word access with be=1111.
  - Loads return the raw dmem_rdata.
  - Misaligned means addr[1:0]≠0.

## Test plan
- Reset: hold rst=0 for 2 cycles during a WAIT with dmem_ack=0 → state IDLE, dmem_req=0, stall=0, all registered outputs 0.
- Word load, addr 0x100: ack on 3rd WAIT cycle with rdata 0xDEADBEEF → stall high for 4 cycles, then mem_read_data=0xDEADBEEF, reg_write_out=1 for one cycle.
- Byte load, addr 0x103, rdata 0x80112233:
  - signed → 0xFFFFFF80.
  - mem_unsigned → 0x00000080.
- Half store, addr 0x202, data 0x0000ABCD → dmem_we=1, be=1100, wdata=0xABCDABCD, reg_write_out=0 in DONE.
- Word load, addr 0x101 → misalign_exc=1 for one cycle, dmem_req never rises, reg_write_out=0, stall=0.
- Non-memory add, alu_result 0x42, reg_write=1 → same-cycle pass-through; a spurious dmem_ack in IDLE has no effect.
